l2_inv_ack_collector: RTL
=========================

Name: l2_inv_ack_collector

Overview:
- Sits on the msg3 (L1->L2 response) path directly upstream of the L2 INV_FWDACK state update.
- Holds the sharer set of one outstanding invalidation and consumes INV_FWDACK (type 8'h17) messages on msg3.
- Clears one pending bit per matching ack.
- When all bits are clear, or a timeout expires, emits one completion token. The L2 uses that token to move cache_state to 0 and cur_msg_state to 2.

Parameters:
NUM_SHARERS, 64, width of sharer mask / share_list
SRC_W, 6, msg source id width (log2 NUM_SHARERS)
TAG_W, 26, tag width
TYPE_W, 8, message type width
TIMEOUT_LIMIT, 200, cycles in COLLECT before forced completion (1..255)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start_valid  in  1  new invalidation round request
start_ready  out  1  collector can accept a round (IDLE)
start_tag  in  TAG_W  tag under invalidation
start_mask  in  NUM_SHARERS  sharers that owe an ack (share_list snapshot)
msg3_valid  in  1  response message valid
msg3_ready  out  1  collector consumes msg3 this cycle
msg3_type  in  TYPE_W  response type
msg3_source  in  SRC_W  responding L1 id
msg3_tag  in  TAG_W  response tag
done_valid  out  1  round complete
done_ready  in  1  consumer accepts completion
done_tag  out  TAG_W  tag of completed round
done_timeout  out  1  round ended by timeout, not by full ack set
pending_mask  out  NUM_SHARERS  sharers still owing an ack
busy  out  1  state != IDLE
err_unexpected  out  1  one-cycle pulse: consumed INV_FWDACK was not expected

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; pending_mask=0; done_tag=0; done_timeout=0; timer=0; err_unexpected=0.
  - Combinational outputs follow state: start_ready=1, msg3_ready=0, done_valid=0, busy=0.
  - Reset mid-round discards the round. No done token is produced.
- States: IDLE, COLLECT, DONE.
- IDLE:
  - start_ready=1.
  - On start_valid: latch start_tag into done_tag, clear timer.
  - start_mask==0 -> DONE next cycle, with done_timeout=0.
  - Otherwise load pending_mask=start_mask, clear done_timeout, go to COLLECT.
- COLLECT:
  - msg3_ready = msg3_type==8'h17. Other types are never consumed; they remain for other consumers.
  - Handshake = msg3_valid & msg3_ready.
  - On a handshake with msg3_tag==done_tag and pending_mask[msg3_source]==1: clear that bit next cycle.
  - On any other handshake: the message is dropped and err_unexpected pulses high the next cycle for exactly 1 cycle.
  - Timer increments each cycle and saturates at 255.
- COLLECT exits:
  - If the next pending_mask is all zero -> DONE, done_timeout=0. The last-ack cycle sets DONE on the following edge.
  - Else if timer==TIMEOUT_LIMIT-1 -> DONE, done_timeout=1. pending_mask is held and shows the missing sharers.
  - If the last ack and the timeout land in the same cycle, the ack wins: done_timeout=0.
- DONE:
  - done_valid=1; done_tag and done_timeout are stable; msg3_ready=0; start_ready=0.
  - On done_ready -> IDLE. pending_mask clears on that same edge.
- Latency: the ack that clears the final bit is followed by done_valid exactly 1 cycle later.
- Throughput: 1 ack per cycle.
- A start_valid that arrives while not IDLE is ignored (start_ready=0 back-pressures it).

Decomposition:
- Shared package l2_msg_pkg holds the message type constants (MSG_INV_FWDACK=8'h17 and siblings), the TAG_W/SRC_W/TYPE_W defaults, and the collector state enum.
- One sub-module is natural: l2_ack_timer, the saturating 8-bit counter with clear/enable and a hit output compared against TIMEOUT_LIMIT.

Test Plan:
- Full ack set: start_mask=64'h5, tag=26'h123. Send INV_FWDACK from src 0 then src 2, same tag.
  - pending_mask goes 5->4->0; done_valid one cycle after the 2nd ack; done_timeout=0; done_tag=26'h123.
- Bad ack: start_mask=64'h1. Send INV_FWDACK from src 3, then one with tag 26'h999.
  - Both are consumed; err_unexpected pulses once for each; pending_mask stays 1.
- Timeout: start_mask=64'h3, TIMEOUT_LIMIT=10. Send only the ack from src 1.
  - done_valid after 10 COLLECT cycles; done_timeout=1; pending_mask=64'h1.
- Type filter and zero mask: msg3_type=8'h10 during COLLECT -> msg3_ready=0.
  - start_mask=0 -> done_valid the cycle after start; done_ready held low 5 cycles keeps done_valid=1 and start_ready=0.
- Async reset: assert rst_n=0 mid-COLLECT with pending_mask=64'hF0.
  - Immediately pending_mask=0, busy=0, done_valid=0; no done token after release.

Source files
------------

// File: rtl/l2_msg_pkg.sv
// Shared L2 message definitions: response type codes, default field widths
// and the invalidation-ack collector state encoding.
package l2_msg_pkg;

    localparam int unsigned NUM_SHARERS_DEF = 64;
    localparam int unsigned SRC_W_DEF       = 6;
    localparam int unsigned TAG_W_DEF       = 26;
    localparam int unsigned TYPE_W_DEF      = 8;
    localparam int unsigned TIMER_W         = 8;

    localparam logic [7:0] MSG_INV_ACK     = 8'h15;
    localparam logic [7:0] MSG_FWD_ACK     = 8'h16;
    localparam logic [7:0] MSG_INV_FWDACK  = 8'h17;
    localparam logic [7:0] MSG_WB_ACK      = 8'h18;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DONE    = 2'd2
    } coll_state_e;

endpackage

// File: rtl/l2_ack_timer.sv
// Saturating round timer; hit_c_o flags the last cycle before forced completion.
module l2_ack_timer
    import l2_msg_pkg::*;
#(
    parameter int unsigned LIMIT = 200
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic hit_c_o
);

    localparam logic [TIMER_W-1:0] CNT_MAX = {TIMER_W{1'b1}};
    localparam logic [TIMER_W-1:0] HIT_VAL = TIMER_W'(LIMIT - 1);

    logic [TIMER_W-1:0] cnt_q;
    logic [TIMER_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + TIMER_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign hit_c_o = (cnt_q == HIT_VAL);

endmodule

// File: rtl/l2_inv_ack_collector.sv
// Collects INV_FWDACK responses for one outstanding invalidation and emits a
// single completion token once every sharer has acked or the round times out.
module l2_inv_ack_collector
    import l2_msg_pkg::*;
#(
    parameter int unsigned NUM_SHARERS   = NUM_SHARERS_DEF,
    parameter int unsigned SRC_W         = SRC_W_DEF,
    parameter int unsigned TAG_W         = TAG_W_DEF,
    parameter int unsigned TYPE_W        = TYPE_W_DEF,
    parameter int unsigned TIMEOUT_LIMIT = 200
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start_valid,
    output logic                   start_ready,
    input  logic [TAG_W-1:0]       start_tag,
    input  logic [NUM_SHARERS-1:0] start_mask,
    input  logic                   msg3_valid,
    output logic                   msg3_ready,
    input  logic [TYPE_W-1:0]      msg3_type,
    input  logic [SRC_W-1:0]       msg3_source,
    input  logic [TAG_W-1:0]       msg3_tag,
    output logic                   done_valid,
    input  logic                   done_ready,
    output logic [TAG_W-1:0]       done_tag,
    output logic                   done_timeout,
    output logic [NUM_SHARERS-1:0] pending_mask,
    output logic                   busy,
    output logic                   err_unexpected
);

    coll_state_e            state_q, state_d;
    logic [NUM_SHARERS-1:0] pending_q, pending_d;
    logic [TAG_W-1:0]       tag_q, tag_d;
    logic                   timeout_q, timeout_d;
    logic                   err_q, err_d;

    logic                   start_hs;
    logic                   ack_hs;
    logic                   ack_match;
    logic [NUM_SHARERS-1:0] clear_vec;
    logic [NUM_SHARERS-1:0] pend_after;
    logic                   timer_hit;

    assign start_hs   = (state_q == ST_IDLE) && start_valid;
    assign ack_hs     = msg3_valid && msg3_ready;
    assign ack_match  = ack_hs && (msg3_tag == tag_q) && pending_q[msg3_source];
    assign clear_vec  = ack_match ? (NUM_SHARERS'(1) << msg3_source) : '0;
    assign pend_after = pending_q & ~clear_vec;

    l2_ack_timer #(.LIMIT(TIMEOUT_LIMIT)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (start_hs),
        .en_i    (state_q == ST_COLLECT),
        .hit_c_o (timer_hit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A final ack takes priority over a coincident timeout.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start_valid) begin
                    state_d = (start_mask == '0) ? ST_DONE : ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if ((pend_after == '0) || timer_hit) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (done_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        start_ready = 1'b0;
        msg3_ready  = 1'b0;
        done_valid  = 1'b0;
        busy        = 1'b1;
        unique case (state_q)
            ST_IDLE: begin
                start_ready = 1'b1;
                busy        = 1'b0;
            end
            ST_COLLECT: msg3_ready = (msg3_type == TYPE_W'(MSG_INV_FWDACK));
            ST_DONE:    done_valid = 1'b1;
            default:    busy = 1'b1;
        endcase
    end

    // Round payload: sharer mask, tag, completion cause and error pulse.
    always_comb begin
        pending_d = pending_q;
        tag_d     = tag_q;
        timeout_d = timeout_q;
        err_d     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start_valid) begin
                    tag_d     = start_tag;
                    timeout_d = 1'b0;
                    pending_d = start_mask;
                end
            end
            ST_COLLECT: begin
                pending_d = pend_after;
                err_d     = ack_hs && !ack_match;
                if ((pend_after != '0) && timer_hit) begin
                    timeout_d = 1'b1;
                end
            end
            ST_DONE: begin
                if (done_ready) begin
                    pending_d = '0;
                end
            end
            default: pending_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
            tag_q     <= '0;
            timeout_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            tag_q     <= tag_d;
            timeout_q <= timeout_d;
            err_q     <= err_d;
        end
    end

    assign pending_mask   = pending_q;
    assign done_tag       = tag_q;
    assign done_timeout   = timeout_q;
    assign err_unexpected = err_q;

endmodule
